// File: rtl/rotate_point.sv
`default_nettype none
// ============================================================================
// Module   : rotate_point
// Function : Rotates a signed (x, y) point by a first-quadrant angle plus a
//            multiple of 90 degrees. Sine/cosine come from an external LUT that
//            holds values scaled by 100. The products are divided back by 100
//            with a sign-magnitude restoring divider.
// Revision : 1.0  initial release
// ============================================================================
module rotate_point #(
   parameter int N = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic signed [N-1:0] x,
   input  logic signed [N-1:0] y,
   input  logic [3:0]          angle_idx,
   input  logic [1:0]          quad,
   output logic [7:0]          sin_addr,
   input  logic [7:0]          sin_data,
   output logic                busy,
   output logic                done,
   output logic signed [N+1:0] rx,
   output logic signed [N+1:0] ry
);

   // |x*c' - y*s'| < 2^(N+7), so N+8 signed bits never overflow
   localparam int PW = N + 8;
   // Dividend magnitude width; one divider iteration per bit
   localparam int DW = 2 * N - 1;
   localparam int CW = $clog2(DW);
   localparam logic [CW-1:0] C_LAST    = CW'(DW - 1);
   localparam logic [7:0]    C_DIVISOR = 8'd100;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOOK_S = 3'd1;
   localparam logic [2:0] S_LOOK_C = 3'd2;
   localparam logic [2:0] S_MUL    = 3'd3;
   localparam logic [2:0] S_DIV    = 3'd4;

   logic [2:0]          state_q, state_d;
   logic signed [N-1:0] x_q, y_q;
   logic [1:0]          quad_q;
   logic [3:0]          i_q;
   logic [7:0]          s_q, c_q;
   logic                negx_q, negy_q;
   logic [6:0]          remx_q, remy_q;
   logic [DW-1:0]       dqx_q, dqy_q;
   logic [CW-1:0]       cnt_q;
   logic signed [N+1:0] rx_q, ry_q;
   logic                done_q;

   logic signed [8:0]    w_s, w_c, w_sp, w_cp;
   logic signed [PW-1:0] w_px, w_py;
   logic [PW-1:0]        w_pxm, w_pym;
   logic [6+DW:0]        w_stepx_d, w_stepy_d;
   logic [N+1:0]         w_qx, w_qy;
   logic [3:0]           w_idx_clamped;
   logic                 w_last;

   // One restoring step: shift the next dividend bit into the remainder
   // (always < 100, so 7 bits), subtract 100 if it fits, and shift the
   // quotient bit into the vacated LSB of the dividend register.
   function automatic logic [6+DW:0] div_step(input logic [6:0] rem,
                                              input logic [DW-1:0] dq);
      logic [7:0] shifted;
      logic [6:0] rem_new;
      logic       qbit;
      shifted = {rem, dq[DW-1]};
      qbit    = (shifted >= C_DIVISOR);
      rem_new = qbit ? 7'(shifted - C_DIVISOR) : shifted[6:0];
      return {rem_new, dq[DW-2:0], qbit};
   endfunction

   assign w_idx_clamped = (angle_idx > 4'd9) ? 4'd9 : angle_idx;
   assign w_last        = (state_q == S_DIV) && (cnt_q == C_LAST);

   // LUT address: sine index in LOOK_S, complementary (cosine) index in LOOK_C
   always_comb begin
      sin_addr = 8'h00;
      case (state_q)
         S_LOOK_S: sin_addr = {i_q, 4'b0000};
         S_LOOK_C: sin_addr = {4'd9 - i_q, 4'b0000};
         default:  sin_addr = 8'h00;
      endcase
   end

   // Quadrant fold, rotation products and their sign-magnitude split
   always_comb begin
      w_s = $signed({1'b0, s_q});
      w_c = $signed({1'b0, c_q});
      case (quad_q)
         2'd0:    begin w_sp = w_s;  w_cp = w_c;  end
         2'd1:    begin w_sp = w_c;  w_cp = -w_s; end
         2'd2:    begin w_sp = -w_s; w_cp = -w_c; end
         default: begin w_sp = -w_c; w_cp = w_s;  end
      endcase
      w_px  = PW'(x_q) * PW'(w_cp) - PW'(y_q) * PW'(w_sp);
      w_py  = PW'(x_q) * PW'(w_sp) + PW'(y_q) * PW'(w_cp);
      w_pxm = w_px[PW-1] ? -w_px : w_px;
      w_pym = w_py[PW-1] ? -w_py : w_py;
   end

   // Divider step results and signed quotients for the final iteration
   always_comb begin
      w_stepx_d = div_step(remx_q, dqx_q);
      w_stepy_d = div_step(remy_q, dqy_q);
      w_qx      = (N+2)'(w_stepx_d[DW-1:0]);
      w_qy      = (N+2)'(w_stepy_d[DW-1:0]);
   end

   // Sequencer next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_LOOK_S;
         S_LOOK_S: state_d = S_LOOK_C;
         S_LOOK_C: state_d = S_MUL;
         S_MUL:    state_d = S_DIV;
         S_DIV:    if (w_last) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Operand capture, divider iterations and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         quad_q  <= '0;
         i_q     <= '0;
         s_q     <= '0;
         c_q     <= '0;
         negx_q  <= 1'b0;
         negy_q  <= 1'b0;
         remx_q  <= '0;
         remy_q  <= '0;
         dqx_q   <= '0;
         dqy_q   <= '0;
         cnt_q   <= '0;
         rx_q    <= '0;
         ry_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  x_q    <= x;
                  y_q    <= y;
                  quad_q <= quad;
                  i_q    <= w_idx_clamped;
               end
            end
            S_LOOK_S: s_q <= sin_data;
            S_LOOK_C: c_q <= sin_data;
            S_MUL: begin
               negx_q <= w_px[PW-1];
               negy_q <= w_py[PW-1];
               dqx_q  <= DW'(w_pxm);
               dqy_q  <= DW'(w_pym);
               remx_q <= '0;
               remy_q <= '0;
               cnt_q  <= '0;
            end
            S_DIV: begin
               {remx_q, dqx_q} <= w_stepx_d;
               {remy_q, dqy_q} <= w_stepy_d;
               cnt_q           <= cnt_q + 1'b1;
               if (w_last) begin
                  // Negating a zero quotient yields zero, so -0 never appears
                  rx_q   <= negx_q ? -w_qx : w_qx;
                  ry_q   <= negy_q ? -w_qy : w_qy;
                  done_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign rx   = rx_q;
   assign ry   = ry_q;

endmodule
`default_nettype wire

// File: tb/tb_rotate_point.sv
`default_nettype none
// ============================================================================
// Module   : tb_rotate_point
// Function : Self-checking bench for rotate_point with an external sine LUT.
// Revision : 1.0  initial release
// ============================================================================
module tb_rotate_point;

   localparam int N = 8;

   logic                clk = 1'b0;
   logic                reset, start;
   logic signed [N-1:0] x, y;
   logic [3:0]          angle_idx;
   logic [1:0]          quad;
   logic [7:0]          sin_addr, sin_data;
   logic                busy, done;
   logic signed [N+1:0] rx, ry;

   int tests = 0;
   int fails = 0;
   int lut [10] = '{5, 21, 36, 50, 65, 76, 86, 94, 98, 100};

   typedef struct {
      int x, y, idx, q;
      int erx, ery, eas, eac;
   } vec_t;

   rotate_point #(.N(N)) dut (
      .clk(clk), .reset(reset), .start(start), .x(x), .y(y),
      .angle_idx(angle_idx), .quad(quad), .sin_addr(sin_addr),
      .sin_data(sin_data), .busy(busy), .done(done), .rx(rx), .ry(ry)
   );

   always #5 clk = ~clk;

   // External LUT: combinational, indexed by sin_addr[7:4]
   always_comb begin
      int k;
      k = int'(sin_addr[7:4]);
      sin_data = (k <= 9) ? 8'(lut[k]) : 8'd0;
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: rotate the unit vector (c, s) by quad*90 degrees, then the
   // point, then divide by 100 with C-style truncation toward zero.
   function automatic void model(input int xi, input int yi, input int idx,
                                 input int q, output int erx, output int ery);
      int i, s, c, t;
      i = (idx > 9) ? 9 : idx;
      s = lut[i];
      c = lut[9 - i];
      repeat (q) begin
         t = c; c = -s; s = t;
      end
      erx = (xi * c - yi * s) / 100;
      ery = (xi * s + yi * c) / 100;
   endfunction

   // Wait for done after the accepting edge; returns cycles from that edge
   task automatic wait_done(input int first, output int lat);
      lat = -1;
      for (int cyc = first; cyc <= 40; cyc++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = cyc;
            break;
         end
      end
   endtask

   task automatic run_op(input int xi, input int yi, input int idx, input int q,
                         output int orx, output int ory,
                         output int a_s, output int a_c);
      int lat;
      @(negedge clk);
      x = N'(xi); y = N'(yi); angle_idx = 4'(idx); quad = 2'(q); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a_s = int'(sin_addr);
      check("busy_after_start", int'(busy), 1);
      @(posedge clk); #1;
      a_c = int'(sin_addr);
      wait_done(2, lat);
      check("latency", lat, 18);
      orx = int'(rx);
      ory = int'(ry);
      if (lat >= 0) begin
         check("busy_at_done", int'(busy), 0);
         @(posedge clk); #1;
         check("done_one_cycle", int'(done), 0);
         check("rx_hold", int'(rx), orx);
      end
   endtask

   initial begin
      #500000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      vec_t vecs [9];
      int   grx, gry, gas, gac, erx, ery, lat, ndone;
      int   xi, yi, idx, q;

      vecs[0] = '{100,    0,  0, 0,  100,    5, 8'h00, 8'h90};
      vecs[1] = '{ 10,   20,  4, 0,   -5,   21, 8'h40, 8'h50};
      vecs[2] = '{100,    0,  0, 2, -100,   -5, 8'h00, 8'h90};
      vecs[3] = '{100,    0, 12, 2,   -5, -100, 8'h90, 8'h00};
      vecs[4] = '{-128, -128, 9, 0,  121, -134, 8'h90, 8'h00};
      vecs[5] = '{100,    0,  0, 1,   -5,  100, 8'h00, 8'h90};
      vecs[6] = '{  0,   50,  0, 3,   50,    2, 8'h00, 8'h90};
      vecs[7] = '{ -1,    0,  0, 0,   -1,    0, 8'h00, 8'h90};
      vecs[8] = '{-127, 127,  3, 1,  -45, -172, 8'h30, 8'h60};

      reset = 1'b1; start = 1'b0; x = '0; y = '0; angle_idx = '0; quad = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_rx", int'(rx), 0);
      check("reset_ry", int'(ry), 0);
      check("reset_sin_addr", int'(sin_addr), 0);
      @(negedge clk);
      reset = 1'b0;

      // Directed vectors
      foreach (vecs[k]) begin
         run_op(vecs[k].x, vecs[k].y, vecs[k].idx, vecs[k].q, grx, gry, gas, gac);
         check($sformatf("vec%0d_rx", k), grx, vecs[k].erx);
         check($sformatf("vec%0d_ry", k), gry, vecs[k].ery);
         check($sformatf("vec%0d_addr_s", k), gas, vecs[k].eas);
         check($sformatf("vec%0d_addr_c", k), gac, vecs[k].eac);
      end

      // Randomized operations against the reference model
      for (int n = 0; n < 40; n++) begin
         xi  = int'($urandom_range(0, 255)) - 128;
         yi  = int'($urandom_range(0, 255)) - 128;
         idx = int'($urandom_range(0, 15));
         q   = int'($urandom_range(0, 3));
         model(xi, yi, idx, q, erx, ery);
         run_op(xi, yi, idx, q, grx, gry, gas, gac);
         check($sformatf("rand%0d_rx", n), grx, erx);
         check($sformatf("rand%0d_ry", n), gry, ery);
      end

      // Start during busy is ignored; start in the done cycle is accepted
      @(negedge clk);
      x = 8'sd10; y = 8'sd20; angle_idx = 4'd4; quad = 2'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0;
      lat = -1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (cyc == 5) begin
            x = 8'sd100; y = 8'sd0; angle_idx = 4'd9; quad = 2'd2; start = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            ndone++;
            if (lat < 0) begin
               lat = cyc;
               grx = int'(rx);
               gry = int'(ry);
            end
         end
      end
      check("ignore_done_count", ndone, 1);
      check("ignore_latency", lat, 18);
      check("ignore_rx", grx, -5);
      check("ignore_ry", gry, 21);

      @(negedge clk);
      x = 8'sd10; y = 8'sd20; angle_idx = 4'd4; quad = 2'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(1, lat);
      check("b2b_first_latency", lat, 18);
      x = 8'sd100; y = 8'sd0; angle_idx = 4'd0; quad = 2'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_accepted", int'(busy), 1);
      wait_done(1, lat);
      check("b2b_second_latency", lat, 18);
      check("b2b_rx", int'(rx), 100);
      check("b2b_ry", int'(ry), 5);

      // Reset during DIV aborts with no done pulse
      @(negedge clk);
      x = -8'sd128; y = -8'sd128; angle_idx = 4'd9; quad = 2'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_div_busy", int'(busy), 0);
      check("rst_div_done", int'(done), 0);
      check("rst_div_rx", int'(rx), 0);
      check("rst_div_ry", int'(ry), 0);
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("rst_div_no_done", ndone, 0);
      run_op(-128, -128, 9, 0, grx, gry, gas, gac);
      check("after_rst_rx", grx, 121);
      check("after_rst_ry", gry, -134);

      // Reset wins over a simultaneous start
      @(negedge clk);
      reset = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      check("rst_prio_busy", int'(busy), 0);
      @(negedge clk);
      reset = 1'b0; start = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
